eth_rx_frame: RTL and testbench
===============================

Name: eth_rx_frame

Overview:
- Parametrised next-generation Ethernet receive front end; replaces the chained ether/bitorder/firewall/ethertype/cksum path with one frame FSM.
- Accepts RMII dibits (N=2) or MII nibbles (N=4) and strips preamble/SFD.
- Assembles bytes LSB-first, filters on destination MAC (unicast/broadcast/promiscuous), and extracts the full 16-bit ethertype and source MAC.
- Streams payload bytes with FCS removed and checks CRC-32, length and alignment. Ends each frame with exactly one done or kill pulse and a reason code. Feeds the IP/packet layer.

Parameters:
- N, 2, symbol width per clk (2 = RMII dibit, 4 = MII nibble); other values illegal (elaboration error).
- MIN_LEN, 64, minimum frame bytes from DA through FCS inclusive.
- MAX_LEN, 1518, maximum frame bytes from DA through FCS inclusive.
- PROMISC, 0, 1 = accept any destination MAC.

Ports:
- clk  in  1  receive clock (50 MHz RMII / 25 MHz MII).
- rst  in  1  asynchronous, active-low reset.
- rxd  in  N  receive symbol, first-on-wire bit in rxd[0].
- crsdv  in  1  carrier/data valid; a low level ends the frame.
- my_mac  in  48  station MAC, first-on-wire octet in [47:40].
- axiod  out  8  payload byte.
- axiov  out  1  axiod valid.
- axiol  out  1  last payload byte of frame; qualified by axiov.
- ethertype  out  16  type/length field, first octet in [15:8].
- ethertype_valid  out  1  ethertype and src_mac valid; held until next SFD.
- src_mac  out  48  source MAC of current frame.
- frame_len  out  11  bytes DA..FCS; saturates at 2047; valid with rx_done/rx_kill.
- rx_done  out  1  one-cycle pulse: good frame.
- rx_kill  out  1  one-cycle pulse: bad frame; discard any bytes streamed.
- kill_reason  out  3  valid with rx_kill; 1 CRC, 2 runt, 3 giant, 4 MAC mismatch, 5 alignment.

Behaviour:
- Reset (rst=0, async): every output is 0; FSM goes to WAIT_IDLE; CRC register is 0xFFFFFFFF; delay line is empty.
- FSM states:
  - WAIT_IDLE: leave when crsdv=0, to IDLE.
  - IDLE: crsdv=1 and rxd=preamble symbol (N=2: 2'b01; N=4: 4'h5) goes to PREAMBLE. crsdv=1 with any other symbol goes to WAIT_IDLE.
  - PREAMBLE: preamble symbol stays. SFD symbol (N=2: 2'b11; N=4: 4'hD) goes to DEST; clears counters and the delay line; drops ethertype_valid. Any other symbol, or crsdv=0, goes to WAIT_IDLE silently, with no pulse.
  - DEST: 6 bytes. On the 6th byte, accept if DA==my_mac, DA==48'hFFFF_FFFF_FFFF, or PROMISC; otherwise go to DROP with pending reason 4.
  - SRC: 6 bytes into src_mac.
  - TYPE: 2 bytes. ethertype_valid rises the cycle after the 14th byte completes.
  - PAYLOAD: until crsdv=0.
  - DROP: no axiov; wait for crsdv=0.
  - All post-SFD states go to IDLE when crsdv=0.
- Byte assembly: symbol k of a byte goes to bits [kN+N-1:kN]. A byte completes every 8/N valid cycles. The byte counter increments on completion.
- CRC-32: reflected poly 0xEDB88320, init 0xFFFFFFFF, fed every completed byte after SFD including FCS. Good iff the register equals residue 0xDEBB20E3 at frame end.
- FCS stripping: 5-byte delay line. Payload byte k (counted from byte 14) is emitted one cycle after byte k+5 completes. At frame end, the oldest payload byte still held is emitted with axiov=1 and axiol=1. The remaining 4 held bytes (FCS) are discarded. If no payload byte is held, no axiol.
- Frame end, first cycle with crsdv=0 after SFD: rx_done or rx_kill pulses on the next cycle, aligned with the axiol byte.
- Kill priority, first match wins:
  1. crsdv fell with a partial byte → 5.
  2. Pending MAC mismatch → 4.
  3. Length > MAX_LEN → 3.
  4. Length < MIN_LEN → 2.
  5. CRC bad → 1.
- Giant: once the count exceeds MAX_LEN, go to DROP; the kill is issued at frame end.
- Back-to-back frames: IDLE accepts a new preamble the cycle after crsdv returns high. Ethertype/src_mac are held until the next SFD.
- Reset mid-frame: the frame is discarded with no pulse. If crsdv is still high after release, WAIT_IDLE waits for crsdv=0.
- No backpressure: the consumer must accept every axiov byte.

Decomposition:
- Package eth_pkg: N-dependent preamble/SFD symbol constants; CRC poly, init and residue; broadcast MAC; MIN/MAX defaults; kill_reason enum; FSM state enum; header offsets (6, 12, 14).
- Sub-module crc32_byte: byte-wide CRC register with init and enable inputs, and match-residue output.

Test Plan:
- N=2, 7×0x55+0xD5, DA=my_mac=02:00:00:00:00:01, type 0x0800, 46-byte payload 0x00..0x2D, correct FCS → 46 axiov bytes 0x00..0x2D; axiol on 0x2D; rx_done; frame_len=64; ethertype=0x0800.
- Same frame with 1 FCS bit flipped → all payload streamed; rx_kill with kill_reason=1.
- DA=FF:FF:FF:FF:FF:FF → accepted, rx_done. DA=02:00:00:00:00:02 with PROMISC=0 → no axiov, kill_reason=4. Same frame with PROMISC=1 → rx_done.
- 60-byte frame → kill_reason=2, frame_len=60. 1519-byte frame → kill_reason=3. crsdv drops after an odd dibit → kill_reason=5.
- N=4 instance, preamble nibbles 0x5 then 0xD, same 64-byte frame → identical axiod stream and rx_done.
- rst pulled low mid-payload, released with crsdv high → no pulse. Next valid frame after crsdv low → normal rx_done.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared constants, enums and the CRC-32 byte update for the Ethernet receive front end.
package eth_pkg;

  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [47:0] BCAST_MAC   = 48'hFFFF_FFFF_FFFF;

  localparam int MIN_LEN_DEF = 64;
  localparam int MAX_LEN_DEF = 1518;

  // Header offsets in bytes from the first DA octet.
  localparam int HDR_DA_END   = 6;
  localparam int HDR_SA_END   = 12;
  localparam int HDR_TYPE_END = 14;

  typedef enum logic [2:0] {
    KILL_NONE  = 3'd0,
    KILL_CRC   = 3'd1,
    KILL_RUNT  = 3'd2,
    KILL_GIANT = 3'd3,
    KILL_MAC   = 3'd4,
    KILL_ALIGN = 3'd5
  } kill_reason_e;

  typedef enum logic [2:0] {
    S_WAIT_IDLE,
    S_IDLE,
    S_PREAMBLE,
    S_DEST,
    S_SRC,
    S_TYPE,
    S_PAYLOAD,
    S_DROP
  } rx_state_e;

  // Preamble and SFD symbols as they appear per clock, first-on-wire bit in bit 0.
  function automatic logic [3:0] pre_sym(input int n);
    return (n == 2) ? 4'h1 : 4'h5;
  endfunction

  function automatic logic [3:0] sfd_sym(input int n);
    return (n == 2) ? 4'h3 : 4'hD;
  endfunction

  // Reflected CRC-32 advanced by one byte, LSB of the byte first.
  function automatic logic [31:0] crc32_next(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ CRC_POLY;
      else                c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_rx_frame_if.sv
// Receive-side bus: MII/RMII symbols in, payload stream and frame status out.
// The stream has no backpressure: axiod is valid for exactly the cycle axiov is
// high and must be taken then; axiol marks the final payload byte and only
// counts when axiov is high; rx_done/rx_kill are single-cycle pulses.
interface eth_rx_frame_if #(parameter int N = 2);
  import eth_pkg::*;

  logic [N-1:0] rxd;
  logic         crsdv;
  logic [47:0]  my_mac;
  logic [7:0]   axiod;
  logic         axiov;
  logic         axiol;
  logic [15:0]  ethertype;
  logic         ethertype_valid;
  logic [47:0]  src_mac;
  logic [10:0]  frame_len;
  logic         rx_done;
  logic         rx_kill;
  logic [2:0]   kill_reason;
  rx_state_e    dbg_state;

  modport master (
    output rxd, crsdv, my_mac,
    input  axiod, axiov, axiol, ethertype, ethertype_valid, src_mac,
    input  frame_len, rx_done, rx_kill, kill_reason, dbg_state
  );

  modport slave (
    input  rxd, crsdv, my_mac,
    output axiod, axiov, axiol, ethertype, ethertype_valid, src_mac,
    output frame_len, rx_done, rx_kill, kill_reason, dbg_state
  );

endinterface

// File: rtl/crc32_byte.sv
// Byte-wide CRC-32 register; match_o flags the good-frame residue.
module crc32_byte
  import eth_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       init_i,
  input  logic       en_i,
  input  logic [7:0] data_i,
  output logic       match_o
);

  logic [31:0] crc_q, crc_d;

  // Next CRC: init wins over a data byte.
  always_comb begin
    crc_d = crc_q;
    if (init_i)    crc_d = CRC_INIT;
    else if (en_i) crc_d = crc32_next(crc_q, data_i);
  end

  // CRC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) crc_q <= CRC_INIT;
    else        crc_q <= crc_d;
  end

  assign match_o = (crc_q == CRC_RESIDUE);

endmodule

// File: rtl/eth_rx_frame.sv
// Ethernet receive front end: preamble/SFD strip, DA filter, header extract,
// FCS-stripped payload stream, CRC/length/alignment check, one done/kill per frame.
module eth_rx_frame
  import eth_pkg::*;
#(
  parameter int N       = 2,
  parameter int MIN_LEN = MIN_LEN_DEF,
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter bit PROMISC = 1'b0
) (
  input logic          clk,
  input logic          rst,
  eth_rx_frame_if.slave bus
);

  if (N != 2 && N != 4) begin : g_bad_n
    $error("eth_rx_frame: N must be 2 or 4");
  end

  localparam int          SPB      = 8 / N;
  localparam logic [1:0]  SYM_LAST = 2'(SPB - 1);
  localparam logic [3:0]  PRE4     = pre_sym(N);
  localparam logic [3:0]  SFD4     = sfd_sym(N);
  localparam logic [10:0] MIN_L    = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L    = 11'(MAX_LEN);

  rx_state_e    state_q, state_d;
  logic [1:0]   sym_q, sym_d;
  logic [7:0]   byte_q, byte_d, cur_byte;
  logic [10:0]  cnt_q, cnt_d;
  logic [39:0]  da_q, da_d;
  logic         mism_q, mism_d;
  logic [39:0]  dl_q, dl_d;          // delay line, oldest byte in [7:0]
  logic [2:0]   dl_cnt_q, dl_cnt_d;
  logic [47:0]  src_q, src_d;
  logic [15:0]  et_q, et_d;
  logic         ev_q, ev_d;
  logic [7:0]   axiod_q, axiod_d;
  logic         axiov_q, axiov_d, axiol_q, axiol_d;
  logic         done_q, done_d, kill_q, kill_d;
  logic [2:0]   reason_q, reason_d;
  logic [10:0]  len_q, len_d;
  logic         crc_init, crc_en, crc_ok;
  logic         post_sfd, byte_done, frame_end, da_ok;
  logic [47:0]  da_full;
  kill_reason_e why;

  crc32_byte u_crc (
    .clk    (clk),
    .rst_n  (rst),
    .init_i (crc_init),
    .en_i   (crc_en),
    .data_i (cur_byte),
    .match_o(crc_ok)
  );

  // Byte being completed this cycle: held symbols plus the current one.
  always_comb begin
    cur_byte = byte_q;
    cur_byte[sym_q*N +: N] = bus.rxd;
  end

  assign post_sfd  = (state_q inside {S_DEST, S_SRC, S_TYPE, S_PAYLOAD, S_DROP});
  assign byte_done = post_sfd && bus.crsdv && (sym_q == SYM_LAST);
  assign frame_end = post_sfd && !bus.crsdv;
  assign da_full   = {da_q, cur_byte};
  assign da_ok     = PROMISC || (da_full == bus.my_mac) || (da_full == BCAST_MAC);

  // Kill reason at frame end, first match wins.
  always_comb begin
    why = KILL_NONE;
    if (sym_q != 2'd0)     why = KILL_ALIGN;
    else if (mism_q)       why = KILL_MAC;
    else if (cnt_q > MAX_L) why = KILL_GIANT;
    else if (cnt_q < MIN_L) why = KILL_RUNT;
    else if (!crc_ok)      why = KILL_CRC;
  end

  // Frame FSM next state and datapath next values.
  always_comb begin
    state_d  = state_q;
    sym_d    = sym_q;
    byte_d   = byte_q;
    cnt_d    = cnt_q;
    da_d     = da_q;
    mism_d   = mism_q;
    dl_d     = dl_q;
    dl_cnt_d = dl_cnt_q;
    src_d    = src_q;
    et_d     = et_q;
    ev_d     = ev_q;
    axiod_d  = axiod_q;
    axiov_d  = 1'b0;
    axiol_d  = 1'b0;
    done_d   = 1'b0;
    kill_d   = 1'b0;
    reason_d = reason_q;
    len_d    = len_q;
    crc_init = 1'b0;
    crc_en   = 1'b0;

    case (state_q)
      S_WAIT_IDLE: if (!bus.crsdv) state_d = S_IDLE;
      S_IDLE: begin
        if (bus.crsdv) state_d = (bus.rxd == PRE4[N-1:0]) ? S_PREAMBLE : S_WAIT_IDLE;
      end
      S_PREAMBLE: begin
        if (!bus.crsdv || (bus.rxd != PRE4[N-1:0] && bus.rxd != SFD4[N-1:0])) begin
          state_d = S_WAIT_IDLE;
        end else if (bus.rxd == SFD4[N-1:0]) begin
          state_d  = S_DEST;
          sym_d    = 2'd0;
          cnt_d    = 11'd0;
          dl_cnt_d = 3'd0;
          mism_d   = 1'b0;
          ev_d     = 1'b0;
          crc_init = 1'b1;
        end
      end
      default: ;
    endcase

    if (post_sfd && bus.crsdv) begin
      sym_d  = (sym_q == SYM_LAST) ? 2'd0 : sym_q + 2'd1;
      byte_d = cur_byte;
    end

    if (byte_done) begin
      crc_en = 1'b1;
      if (cnt_q != 11'h7FF) cnt_d = cnt_q + 11'd1;
      case (state_q)
        S_DEST: begin
          da_d = {da_q[31:0], cur_byte};
          if (cnt_q == 11'(HDR_DA_END - 1)) begin
            if (da_ok) state_d = S_SRC;
            else begin
              state_d = S_DROP;
              mism_d  = 1'b1;
            end
          end
        end
        S_SRC: begin
          src_d = {src_q[39:0], cur_byte};
          if (cnt_q == 11'(HDR_SA_END - 1)) state_d = S_TYPE;
        end
        S_TYPE: begin
          et_d = {et_q[7:0], cur_byte};
          if (cnt_q == 11'(HDR_TYPE_END - 1)) begin
            state_d = S_PAYLOAD;
            ev_d    = 1'b1;
          end
        end
        S_PAYLOAD: begin
          // Five bytes stay in flight so the trailing four (FCS) are never streamed.
          dl_d = {cur_byte, dl_q[39:8]};
          if (dl_cnt_q == 3'd5) begin
            axiov_d = 1'b1;
            axiod_d = dl_q[7:0];
          end else begin
            dl_cnt_d = dl_cnt_q + 3'd1;
          end
        end
        default: ;
      endcase
      if (cnt_d > MAX_L) state_d = S_DROP;
    end

    if (frame_end) begin
      state_d  = S_IDLE;
      sym_d    = 2'd0;
      len_d    = cnt_q;
      reason_d = why;
      done_d   = (why == KILL_NONE);
      kill_d   = (why != KILL_NONE);
      if (state_q == S_PAYLOAD && dl_cnt_q == 3'd5) begin
        axiov_d = 1'b1;
        axiol_d = 1'b1;
        axiod_d = dl_q[7:0];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_WAIT_IDLE;
    else      state_q <= state_d;
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sym_q    <= '0;
      byte_q   <= '0;
      cnt_q    <= '0;
      da_q     <= '0;
      mism_q   <= 1'b0;
      dl_q     <= '0;
      dl_cnt_q <= '0;
      src_q    <= '0;
      et_q     <= '0;
      ev_q     <= 1'b0;
      axiod_q  <= '0;
      axiov_q  <= 1'b0;
      axiol_q  <= 1'b0;
      done_q   <= 1'b0;
      kill_q   <= 1'b0;
      reason_q <= '0;
      len_q    <= '0;
    end else begin
      sym_q    <= sym_d;
      byte_q   <= byte_d;
      cnt_q    <= cnt_d;
      da_q     <= da_d;
      mism_q   <= mism_d;
      dl_q     <= dl_d;
      dl_cnt_q <= dl_cnt_d;
      src_q    <= src_d;
      et_q     <= et_d;
      ev_q     <= ev_d;
      axiod_q  <= axiod_d;
      axiov_q  <= axiov_d;
      axiol_q  <= axiol_d;
      done_q   <= done_d;
      kill_q   <= kill_d;
      reason_q <= reason_d;
      len_q    <= len_d;
    end
  end

  assign bus.axiod           = axiod_q;
  assign bus.axiov           = axiov_q;
  assign bus.axiol           = axiol_q;
  assign bus.ethertype       = et_q;
  assign bus.ethertype_valid = ev_q;
  assign bus.src_mac         = src_q;
  assign bus.frame_len       = len_q;
  assign bus.rx_done         = done_q;
  assign bus.rx_kill         = kill_q;
  assign bus.kill_reason     = reason_q;
  assign bus.dbg_state       = state_q;

endmodule

// File: tb/tb_eth_rx_frame.sv
// Directed bench: RMII (N=2, PROMISC off and on) and MII (N=4) instances.
module tb_eth_rx_frame;
  import eth_pkg::*;

  localparam logic [47:0] MY_MAC = 48'h0200_0000_0001;
  localparam logic [47:0] SA_MAC = 48'h0200_0000_00AA;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  eth_rx_frame_if #(.N(2)) if2 ();
  eth_rx_frame_if #(.N(2)) ifp ();
  eth_rx_frame_if #(.N(4)) if4 ();

  assign ifp.rxd    = if2.rxd;
  assign ifp.crsdv  = if2.crsdv;
  assign if2.my_mac = MY_MAC;
  assign ifp.my_mac = MY_MAC;
  assign if4.my_mac = MY_MAC;

  eth_rx_frame #(.N(2), .PROMISC(1'b0)) u2 (.clk(clk), .rst(rst), .bus(if2));
  eth_rx_frame #(.N(2), .PROMISC(1'b1)) up (.clk(clk), .rst(rst), .bus(ifp));
  eth_rx_frame #(.N(4), .PROMISC(1'b0)) u4 (.clk(clk), .rst(rst), .bus(if4));

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] fr[$];

  // ---------------- monitors ----------------
  logic       clr_req = 1'b0;
  logic [7:0] cap2[$], capp[$], cap4[$];
  int         nlast2, done2, kill2, len2, dl2, donep, killp, nlast4, done4, kill4, len4;
  logic [7:0] last2, last4;
  logic [2:0] reason2, reasonp;

  always @(negedge clk) begin
    if (clr_req) begin
      cap2.delete(); capp.delete(); cap4.delete();
      nlast2 = 0; done2 = 0; kill2 = 0; len2 = 0; dl2 = 0; last2 = 8'h00; reason2 = 3'd0;
      donep = 0; killp = 0; reasonp = 3'd0;
      nlast4 = 0; done4 = 0; kill4 = 0; len4 = 0; last4 = 8'h00;
    end else begin
      if (if2.axiov) begin
        cap2.push_back(if2.axiod);
        if (if2.axiol) begin nlast2++; last2 = if2.axiod; end
      end
      if (if2.rx_done) begin done2++; len2 = int'(if2.frame_len); if (if2.axiol) dl2++; end
      if (if2.rx_kill) begin kill2++; len2 = int'(if2.frame_len); reason2 = if2.kill_reason; end
      if (ifp.axiov) capp.push_back(ifp.axiod);
      if (ifp.rx_done) donep++;
      if (ifp.rx_kill) begin killp++; reasonp = ifp.kill_reason; end
      if (if4.axiov) begin
        cap4.push_back(if4.axiod);
        if (if4.axiol) begin nlast4++; last4 = if4.axiod; end
      end
      if (if4.rx_done) begin done4++; len4 = int'(if4.frame_len); end
      if (if4.rx_kill) kill4++;
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    #1 clr_req = 1'b1;
    @(negedge clk);
    #1 clr_req = 1'b0;
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  // DA, SA, type 0x0800, payload 0,1,2..., FCS (complemented CRC, low byte first).
  task automatic build(input logic [47:0] da, input int plen, input bit flip);
    logic [31:0] c;
    fr.delete();
    for (int i = 5; i >= 0; i--) fr.push_back(da[i*8 +: 8]);
    for (int i = 5; i >= 0; i--) fr.push_back(SA_MAC[i*8 +: 8]);
    fr.push_back(8'h08);
    fr.push_back(8'h00);
    for (int i = 0; i < plen; i++) fr.push_back(8'(i));
    c = 32'hFFFF_FFFF;
    foreach (fr[i]) c = crc_upd(c, fr[i]);
    c = ~c;
    for (int i = 0; i < 4; i++) fr.push_back(c[i*8 +: 8]);
    if (flip) fr[fr.size()-1] = fr[fr.size()-1] ^ 8'h10;
  endtask

  // RMII driver; rst_at >= 0 pulses reset low for 3 bytes starting at that frame byte.
  task automatic send2(input int extra, input int rst_at);
    logic [7:0] b;
    clear_mon();
    for (int i = 0; i < 8 + fr.size(); i++) begin
      if (i < 7)       b = 8'h55;
      else if (i == 7) b = 8'hD5;
      else             b = fr[i-8];
      if (rst_at >= 0 && i - 8 == rst_at)     rst = 1'b0;
      if (rst_at >= 0 && i - 8 == rst_at + 3) rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if2.rxd   = b[2*k +: 2];
        if2.crsdv = 1'b1;
      end
    end
    for (int k = 0; k < extra; k++) begin
      @(negedge clk);
      if2.rxd = 2'b10;
    end
    @(negedge clk);
    if2.crsdv = 1'b0;
    if2.rxd   = 2'b00;
    repeat (5) @(negedge clk);
  endtask

  // MII driver.
  task automatic send4();
    logic [7:0] b;
    clear_mon();
    for (int i = 0; i < 8 + fr.size(); i++) begin
      if (i < 7)       b = 8'h55;
      else if (i == 7) b = 8'hD5;
      else             b = fr[i-8];
      for (int k = 0; k < 2; k++) begin
        @(negedge clk);
        if4.rxd   = b[4*k +: 4];
        if4.crsdv = 1'b1;
      end
    end
    @(negedge clk);
    if4.crsdv = 1'b0;
    if4.rxd   = 4'h0;
    repeat (5) @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    if2.rxd = '0; if2.crsdv = 1'b0;
    if4.rxd = '0; if4.crsdv = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_axiov",  64'(if2.axiov), 64'd0);
    chk("rst_axiod",  64'(if2.axiod), 64'd0);
    chk("rst_done",   64'(if2.rx_done), 64'd0);
    chk("rst_kill",   64'(if2.rx_kill), 64'd0);
    chk("rst_ev",     64'(if2.ethertype_valid), 64'd0);
    chk("rst_type",   64'(if2.ethertype), 64'd0);
    chk("rst_src",    64'(if2.src_mac), 64'd0);
    chk("rst_len",    64'(if2.frame_len), 64'd0);
    chk("rst_reason", 64'(if2.kill_reason), 64'd0);
    chk("rst_state",  64'(if2.dbg_state), 64'(S_WAIT_IDLE));
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_state", 64'(if2.dbg_state), 64'(S_IDLE));

    // good 64-byte frame
    build(MY_MAC, 46, 1'b0);
    send2(0, -1);
    chk("good_cnt", 64'(cap2.size()), 64'd46);
    for (int i = 0; i < 46 && i < cap2.size(); i++) chk($sformatf("good_byte%0d", i), 64'(cap2[i]), 64'(i));
    chk("good_nlast",  64'(nlast2), 64'd1);
    chk("good_last",   64'(last2), 64'h2D);
    chk("good_done",   64'(done2), 64'd1);
    chk("good_kill",   64'(kill2), 64'd0);
    chk("good_align",  64'(dl2), 64'd1);
    chk("good_len",    64'(len2), 64'd64);
    chk("good_type",   64'(if2.ethertype), 64'h0800);
    chk("good_ev",     64'(if2.ethertype_valid), 64'd1);
    chk("good_src",    64'(if2.src_mac), 64'(SA_MAC));
    chk("good_p_done", 64'(donep), 64'd1);

    // FCS bit flipped
    build(MY_MAC, 46, 1'b1);
    send2(0, -1);
    chk("crc_cnt",    64'(cap2.size()), 64'd46);
    chk("crc_done",   64'(done2), 64'd0);
    chk("crc_kill",   64'(kill2), 64'd1);
    chk("crc_reason", 64'(reason2), 64'd1);

    // broadcast DA
    build(BCAST_MAC, 46, 1'b0);
    send2(0, -1);
    chk("bc_done", 64'(done2), 64'd1);
    chk("bc_kill", 64'(kill2), 64'd0);

    // foreign DA: filtered unless promiscuous
    build(48'h0200_0000_0002, 46, 1'b0);
    send2(0, -1);
    chk("mac_cnt",    64'(cap2.size()), 64'd0);
    chk("mac_kill",   64'(kill2), 64'd1);
    chk("mac_reason", 64'(reason2), 64'd4);
    chk("mac_ev",     64'(if2.ethertype_valid), 64'd0);
    chk("prm_done",   64'(donep), 64'd1);
    chk("prm_kill",   64'(killp), 64'd0);
    chk("prm_cnt",    64'(capp.size()), 64'd46);

    // runt
    build(MY_MAC, 42, 1'b0);
    send2(0, -1);
    chk("runt_kill",   64'(kill2), 64'd1);
    chk("runt_reason", 64'(reason2), 64'd2);
    chk("runt_len",    64'(len2), 64'd60);

    // giant
    build(MY_MAC, 1501, 1'b0);
    send2(0, -1);
    chk("giant_kill",   64'(kill2), 64'd1);
    chk("giant_reason", 64'(reason2), 64'd3);
    chk("giant_len",    64'(len2), 64'd1519);
    chk("giant_done",   64'(done2), 64'd0);

    // odd trailing dibit
    build(MY_MAC, 46, 1'b0);
    send2(1, -1);
    chk("align_kill",   64'(kill2), 64'd1);
    chk("align_reason", 64'(reason2), 64'd5);
    chk("align_len",    64'(len2), 64'd64);

    // MII instance, same frame
    build(MY_MAC, 46, 1'b0);
    send4();
    chk("mii_cnt", 64'(cap4.size()), 64'd46);
    for (int i = 0; i < 46 && i < cap4.size(); i++) chk($sformatf("mii_byte%0d", i), 64'(cap4[i]), 64'(i));
    chk("mii_nlast", 64'(nlast4), 64'd1);
    chk("mii_last",  64'(last4), 64'h2D);
    chk("mii_done",  64'(done4), 64'd1);
    chk("mii_kill",  64'(kill4), 64'd0);
    chk("mii_len",   64'(len4), 64'd64);

    // reset mid-payload, released while carrier still up
    build(MY_MAC, 46, 1'b0);
    send2(0, 20);
    chk("rmid_done", 64'(done2), 64'd0);
    chk("rmid_kill", 64'(kill2), 64'd0);

    // next frame recovers
    build(MY_MAC, 46, 1'b0);
    send2(0, -1);
    chk("rec_done", 64'(done2), 64'd1);
    chk("rec_cnt",  64'(cap2.size()), 64'd46);
    chk("rec_len",  64'(len2), 64'd64);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
